// File: rtl/prog_ctr_gen.sv
// Fetch-stage program counter with relative/absolute branching, a call/return
// link stack and a halt/resume state machine.
// Optional feature macro: PC_LINK_STACK_EN (builds the link stack; undefined
// means Call/Ret are ignored and the stack status outputs are held constant).
module prog_ctr_gen #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            branch_rel_i,
  input  logic            branch_abs_i,
  input  logic            zero_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o,
  output logic            stack_full_o,
  output logic            stack_empty_o,
  output logic            stack_err_o
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;

  // Target has the PC width, so a modulo-2^PC_W add is the sign-extended offset.
  assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_LINK_STACK_EN
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  // Shift-register stack: entry 0 is always the top of stack.
  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [PC_W-1:0] stack_d [STACK_DEPTH];
  logic [SpW-1:0]  sp_q, sp_d;
  logic            full_q, empty_q, err_q, err_d;
  logic            push, pop;

  // Next PC, state and stack action, highest-priority request first.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StRun: begin
        if (halt_i) begin
          state_d = StHalted;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (ret_i) begin
          if (!empty_q) begin
            pop  = 1'b1;
            pc_d = stack_q[0];
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end else if (call_i) begin
          if (!full_q) begin
            push = 1'b1;
            pc_d = target_i;
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end else if (branch_abs_i && zero_i) begin
          pc_d = target_i;
        end else if (branch_rel_i && zero_i) begin
          pc_d = pc_q + target_i;
        end else begin
          pc_d = pc_inc;
        end
      end
      StHalted: begin
        if (resume_i && !halt_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Stack contents and pointer follow the push/pop decision.
  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    if (push) begin
      stack_d[0] = pc_inc;
      for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
      sp_d = sp_q + SpW'(1);
    end else if (pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
      stack_d[STACK_DEPTH-1] = '0;
      sp_d = sp_q - SpW'(1);
    end
  end

  // Stack state registers; flags are registered from the next pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      full_q  <= (sp_d == SpW'(STACK_DEPTH));
      empty_q <= (sp_d == '0);
      err_q   <= err_d;
    end
  end

  assign stack_full_o  = full_q;
  assign stack_empty_o = empty_q;
  assign stack_err_o   = err_q;
`else
  logic unused_stack_req;
  assign unused_stack_req = call_i ^ ret_i;

  // Next PC and state; Call/Ret fall through to the branch/increment cases.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (halt_i) begin
          state_d = StHalted;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (branch_abs_i && zero_i) begin
          pc_d = target_i;
        end else if (branch_rel_i && zero_i) begin
          pc_d = pc_q + target_i;
        end else begin
          pc_d = pc_inc;
        end
      end
      StHalted: begin
        if (resume_i && !halt_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign stack_full_o  = 1'b0;
  assign stack_empty_o = 1'b1;
  assign stack_err_o   = 1'b0;
`endif

  // PC and run/halt state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q    <= PC_W'(RESET_VEC);
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc_o     = pc_q;
  assign halted_o = (state_q == StHalted);

endmodule

// File: tb/tb_prog_ctr_gen.sv
// Directed, table-driven bench for prog_ctr_gen (PC_W=8, STACK_DEPTH=4).
module tb_prog_ctr_gen;

  localparam logic [8:0] CR  = 9'h001; // reset
  localparam logic [8:0] CS  = 9'h002; // stall
  localparam logic [8:0] CH  = 9'h004; // halt
  localparam logic [8:0] CU  = 9'h008; // resume
  localparam logic [8:0] CBR = 9'h010; // branch relative
  localparam logic [8:0] CBA = 9'h020; // branch absolute
  localparam logic [8:0] CZ  = 9'h040; // zero flag
  localparam logic [8:0] CC  = 9'h080; // call
  localparam logic [8:0] CT  = 9'h100; // ret
  localparam logic [8:0] CI  = 9'h000; // idle

  typedef struct {
    logic [8:0] ctl;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       halted;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, stall, halt, resume, brel, babs, zero, call, ret;
  logic [7:0] target;
  logic [7:0] pc;
  logic       halted, full, empty, err;

  int checks = 0;
  int errors = 0;

  vec_t tbl [27];

  always #5 clk = ~clk;

  prog_ctr_gen #(.PC_W(8), .STACK_DEPTH(4), .RESET_VEC(0)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .stall_i      (stall),
    .halt_i       (halt),
    .resume_i     (resume),
    .branch_rel_i (brel),
    .branch_abs_i (babs),
    .zero_i       (zero),
    .call_i       (call),
    .ret_i        (ret),
    .target_i     (target),
    .pc_o         (pc),
    .halted_o     (halted),
    .stack_full_o (full),
    .stack_empty_o(empty),
    .stack_err_o  (err)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] ctl, input logic [7:0] tgt);
    reset  = ctl[0];
    stall  = ctl[1];
    halt   = ctl[2];
    resume = ctl[3];
    brel   = ctl[4];
    babs   = ctl[5];
    zero   = ctl[6];
    call   = ctl[7];
    ret    = ctl[8];
    target = tgt;
  endtask

  // Apply one cycle of inputs, then check every output #1 after the edge.
  task automatic step(input int idx, input logic [8:0] ctl, input logic [7:0] tgt,
                      input logic [7:0] e_pc, input logic e_halted, input logic e_empty,
                      input logic e_full, input logic e_err);
    drive(ctl, tgt);
    @(posedge clk);
    #1;
    check("pc", idx, 32'(pc), 32'(e_pc));
    check("halted", idx, 32'(halted), 32'(e_halted));
    check("stack_empty", idx, 32'(empty), 32'(e_empty));
    check("stack_full", idx, 32'(full), 32'(e_full));
    check("stack_err", idx, 32'(err), 32'(e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(CI, 8'd0);
    tbl[0]  = '{CR,              8'd0,   8'd0,   1'b0};
    tbl[1]  = '{CI,              8'd0,   8'd1,   1'b0};
    tbl[2]  = '{CI,              8'd0,   8'd2,   1'b0};
    tbl[3]  = '{CI,              8'd0,   8'd3,   1'b0};
    tbl[4]  = '{CI,              8'd0,   8'd4,   1'b0};
    tbl[5]  = '{CI,              8'd0,   8'd5,   1'b0};
    tbl[6]  = '{CBA | CZ,        8'd10,  8'd10,  1'b0};
    tbl[7]  = '{CBR | CZ,        8'hFE,  8'd8,   1'b0};
    tbl[8]  = '{CBA | CZ,        8'd10,  8'd10,  1'b0};
    tbl[9]  = '{CBR,             8'hFE,  8'd11,  1'b0};  // Zero=0: not taken
    tbl[10] = '{CBA | CZ,        8'hFF,  8'hFF,  1'b0};
    tbl[11] = '{CI,              8'd0,   8'd0,   1'b0};  // FF wraps to 0
    tbl[12] = '{CBA | CZ,        8'd20,  8'd20,  1'b0};
    tbl[13] = '{CBA | CZ,        8'd100, 8'd100, 1'b0};
    tbl[14] = '{CBA | CBR | CZ,  8'd40,  8'd40,  1'b0};  // absolute wins
    tbl[15] = '{CS,              8'd0,   8'd40,  1'b0};
    tbl[16] = '{CS | CBA | CZ,   8'd3,   8'd40,  1'b0};  // stall beats branch
    tbl[17] = '{CBR | CZ,        8'h05,  8'd45,  1'b0};
    tbl[18] = '{CBR | CZ,        8'h80,  8'hAD,  1'b0};  // 45-128 wraps down
    tbl[19] = '{CBA | CZ,        8'd30,  8'd30,  1'b0};
    tbl[20] = '{CH | CC,         8'd99,  8'd30,  1'b0};  // halt beats call
    tbl[21] = '{CU | CH,         8'd0,   8'd30,  1'b1};
    tbl[22] = '{CBA | CZ,        8'd7,   8'd30,  1'b1};
    tbl[23] = '{CU,              8'd0,   8'd30,  1'b1};
    tbl[24] = '{CI,              8'd0,   8'd31,  1'b0};
    tbl[25] = '{CH,              8'd0,   8'd31,  1'b0};
    tbl[26] = '{CR,              8'd0,   8'd0,   1'b1};
    // Halted flag lags the request by the edge that takes it; fix up expectations.
    tbl[20].halted = 1'b1;
    tbl[23].halted = 1'b0;
    tbl[25].halted = 1'b1;
    tbl[26].halted = 1'b0;

    for (int i = 0; i < 27; i++) begin
      step(i, tbl[i].ctl, tbl[i].tgt, tbl[i].pc, tbl[i].halted, 1'b1, 1'b0, 1'b0);
    end

    // Halted for ten cycles ignores a pending call.
    step(100, CBA | CZ, 8'd30, 8'd30, 1'b0, 1'b1, 1'b0, 1'b0);
    step(101, CH | CC, 8'd99, 8'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(102 + i, CC, 8'd99, 8'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    step(112, CU, 8'd0, 8'd30, 1'b0, 1'b1, 1'b0, 1'b0);
    step(113, CI, 8'd0, 8'd31, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef PC_LINK_STACK_EN
    // Nested call/return.
    step(200, CBA | CZ, 8'd5,  8'd5,  1'b0, 1'b1, 1'b0, 1'b0);
    step(201, CC,       8'd50, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0);
    step(202, CC,       8'd70, 8'd70, 1'b0, 1'b0, 1'b0, 1'b0);
    step(203, CT,       8'd0,  8'd51, 1'b0, 1'b0, 1'b0, 1'b0);
    step(204, CT,       8'd0,  8'd6,  1'b0, 1'b1, 1'b0, 1'b0);
    // Fill to four entries, then overflow.
    step(205, CC,       8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(206, CC,       8'd110, 8'd110, 1'b0, 1'b0, 1'b0, 1'b0);
    step(207, CC,       8'd120, 8'd120, 1'b0, 1'b0, 1'b0, 1'b0);
    step(208, CC,       8'd130, 8'd130, 1'b0, 1'b0, 1'b1, 1'b0);
    step(209, CC,       8'd140, 8'd131, 1'b0, 1'b0, 1'b1, 1'b1);
    step(210, CT,       8'd0,   8'd121, 1'b0, 1'b0, 1'b0, 1'b1);
    step(211, CT,       8'd0,   8'd111, 1'b0, 1'b0, 1'b0, 1'b1);
    step(212, CT,       8'd0,   8'd101, 1'b0, 1'b0, 1'b0, 1'b1);
    step(213, CT,       8'd0,   8'd7,   1'b0, 1'b1, 1'b0, 1'b1);
    // Return on empty after reset.
    step(214, CR,       8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    step(215, CT,       8'd0,   8'd1,   1'b0, 1'b1, 1'b0, 1'b1);
    // Reset while halted with two entries discards the stack.
    step(216, CR,       8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    step(217, CC,       8'd40,  8'd40,  1'b0, 1'b0, 1'b0, 1'b0);
    step(218, CC,       8'd60,  8'd60,  1'b0, 1'b0, 1'b0, 1'b0);
    step(219, CH,       8'd0,   8'd60,  1'b1, 1'b0, 1'b0, 1'b0);
    step(220, CR,       8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0);
    step(221, CT,       8'd0,   8'd1,   1'b0, 1'b1, 1'b0, 1'b1);
`else
    // Without the link stack, Call/Ret act as plain increments.
    step(200, CR,            8'd0,  8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(201, CC,            8'd50, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(202, CT,            8'd0,  8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(203, CC | CBA | CZ, 8'd9,  8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step(204, CT | CBR | CZ, 8'hFD, 8'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(205 + i, CC, 8'd50, 8'(7 + i), 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
